// File: rtl/puf_race_controller_pkg.sv
// puf_pkg: shared state encoding and default sizing for the PUF race controller.
package puf_pkg;
    typedef enum logic [2:0] {IDLE, CLEAR, RACE, RECORD, DONE} state_t;
    localparam int DEF_CHAL_WIDTH = 8;
    localparam int DEF_RESP_BITS = 8;
    localparam int DEF_TIMEOUT = 1023;
    localparam int DEF_TIMER_W = $clog2(DEF_TIMEOUT + 1);
endpackage

// File: rtl/puf_race_controller_if.sv
// puf_race_controller_if: challenge/response handshake plus post-mux counter control.
interface puf_race_controller_if #(
    parameter int CHAL_WIDTH = 8,
    parameter int RESP_BITS = 8
);
    logic                  chal_valid;
    logic                  chal_ready;
    logic [CHAL_WIDTH-1:0] chal_data;
    logic [CHAL_WIDTH-1:0] mux_sel;
    logic                  cnt_reset;
    logic                  cnt_enable;
    logic                  finished_a;
    logic                  finished_b;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [RESP_BITS-1:0]  resp_data;
    logic                  tie_seen;
    logic                  timeout_seen;
    modport slave (
        input  chal_valid, chal_data, finished_a, finished_b, resp_ready,
        output chal_ready, mux_sel, cnt_reset, cnt_enable, resp_valid, resp_data, tie_seen, timeout_seen
    );
    modport master (
        output chal_valid, chal_data, finished_a, finished_b, resp_ready,
        input  chal_ready, mux_sel, cnt_reset, cnt_enable, resp_valid, resp_data, tie_seen, timeout_seen
    );
endinterface

// File: rtl/puf_race_timer.sv
// puf_race_timer: cycle counter with synchronous clear, enable and terminal-count flag.
module puf_race_timer #(
    parameter int W = 10,
    parameter int TERMINAL = 1022
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = clr_i ? '0 : en_i ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
    assign tc_o = count_q == W'(TERMINAL);
endmodule

// File: rtl/puf_race_controller.sv
// puf_race_controller: runs one counter race per response bit and returns the packed response.
module puf_race_controller
    import puf_pkg::*;
#(
    parameter int CHAL_WIDTH = DEF_CHAL_WIDTH,
    parameter int RESP_BITS = DEF_RESP_BITS,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TIMER_W = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset,
    puf_race_controller_if.slave bus
);
    localparam int IDX_W = $clog2(RESP_BITS);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CHAL_WIDTH-1:0] chal_q, chal_d;
    logic [CHAL_WIDTH-1:0] mux_q, mux_d;
    logic [RESP_BITS-1:0]  resp_q, resp_d;
    logic                  tie_q, tie_d;
    logic                  to_q, to_d;
    logic                  bit_q, bit_d;
    logic                  tc;

    // Timer reads 0 in the first RACE cycle, so the terminal value TIMEOUT-1 gives TIMEOUT race cycles.
    puf_race_timer #(.W(TIMER_W), .TERMINAL(TIMEOUT - 1)) u_timer (
        .clk   (clk),
        .rst   (reset),
        .clr_i (state_q == CLEAR),
        .en_i  (state_q == RACE),
        .tc_o  (tc)
    );

    always_comb begin
        state_d = state_q;
        idx_d = idx_q;
        chal_d = chal_q;
        mux_d = mux_q;
        resp_d = resp_q;
        tie_d = tie_q;
        to_d = to_q;
        bit_d = bit_q;
        case (state_q)
            IDLE: if (bus.chal_valid) begin
                state_d = CLEAR;
                chal_d = bus.chal_data;
                mux_d = bus.chal_data;
                resp_d = '0;
                tie_d = 1'b0;
                to_d = 1'b0;
                idx_d = '0;
            end
            CLEAR: state_d = RACE;
            RACE: if (bus.finished_a || bus.finished_b || tc) begin
                state_d = RECORD;
                bit_d = bus.finished_a && !bus.finished_b;
                tie_d = tie_q || (bus.finished_a && bus.finished_b);
                to_d = to_q || (!bus.finished_a && !bus.finished_b);
            end
            RECORD: begin
                resp_d = {resp_q[RESP_BITS-2:0], bit_q};
                if (idx_q == IDX_W'(RESP_BITS - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = CLEAR;
                    idx_d = idx_q + 1'b1;
                    mux_d = chal_q + CHAL_WIDTH'(idx_q) + 1'b1;
                end
            end
            DONE: state_d = bus.resp_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q <= '0;
            chal_q <= '0;
            mux_q <= '0;
            resp_q <= '0;
            tie_q <= 1'b0;
            to_q <= 1'b0;
            bit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q <= idx_d;
            chal_q <= chal_d;
            mux_q <= mux_d;
            resp_q <= resp_d;
            tie_q <= tie_d;
            to_q <= to_d;
            bit_q <= bit_d;
        end
    end

    assign bus.chal_ready = state_q == IDLE && !reset;
    assign bus.cnt_reset = reset || state_q == IDLE || state_q == CLEAR || state_q == DONE;
    assign bus.cnt_enable = state_q == RACE && !reset;
    assign bus.resp_valid = state_q == DONE && !reset;
    assign bus.mux_sel = mux_q;
    assign bus.resp_data = resp_q;
    assign bus.tie_seen = tie_q;
    assign bus.timeout_seen = to_q;
endmodule

// File: tb/tb_puf_race_controller.sv
// tb_puf_race_controller: directed checks of race sequencing, packing, flags and handshake.
module tb_puf_race_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    puf_race_controller_if #(.CHAL_WIDTH(8), .RESP_BITS(8)) if0 ();
    puf_race_controller_if #(.CHAL_WIDTH(8), .RESP_BITS(8)) if1 ();

    puf_race_controller #(.CHAL_WIDTH(8), .RESP_BITS(8), .TIMEOUT(1023)) u0 (.clk(clk), .reset(reset), .bus(if0));
    puf_race_controller #(.CHAL_WIDTH(8), .RESP_BITS(8), .TIMEOUT(4)) u1 (.clk(clk), .reset(reset), .bus(if1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] c);
        int n = 0;
        while (!if0.chal_ready && n < 100) begin tick(); n++; end
        chk("chal_ready_wait", {31'd0, if0.chal_ready}, 1);
        if0.chal_data = c;
        if0.chal_valid = 1'b1;
        tick();
        if0.chal_valid = 1'b0;
    endtask

    // code: 0 = A wins, 1 = B wins, 2 = tie; pulse lands in the 5th RACE cycle
    task automatic race(input logic [7:0] m, input logic [1:0] code);
        int n = 0;
        while (!if0.cnt_enable && n < 50) begin tick(); n++; end
        chk("race_start", {31'd0, if0.cnt_enable}, 1);
        chk("mux_sel", {24'd0, if0.mux_sel}, {24'd0, m});
        repeat (4) tick();
        if0.finished_a = code != 2'd1;
        if0.finished_b = code != 2'd0;
        tick();
        if0.finished_a = 1'b0;
        if0.finished_b = 1'b0;
    endtask

    task automatic response(input logic [7:0] c, input logic [15:0] codes);
        int n = 0;
        accept(c);
        for (int i = 0; i < 8; i++) race(8'(c + i), codes[2*i +: 2]);
        while (!if0.resp_valid && n < 20) begin tick(); n++; end
        chk("resp_valid_wait", {31'd0, if0.resp_valid}, 1);
    endtask

    task automatic finish_resp();
        chk("no_accept_in_done", {31'd0, if0.chal_ready}, 0);
        if0.resp_ready = 1'b1;
        tick();
        if0.resp_ready = 1'b0;
        chk("resp_valid_drop", {31'd0, if0.resp_valid}, 0);
        chk("chal_ready_rise", {31'd0, if0.chal_ready}, 1);
    endtask

    initial begin
        logic [7:0] held;
        int n;
        if0.chal_valid = 0; if0.chal_data = 0; if0.finished_a = 0; if0.finished_b = 0; if0.resp_ready = 0;
        if1.chal_valid = 0; if1.chal_data = 0; if1.finished_a = 0; if1.finished_b = 0; if1.resp_ready = 0;
        repeat (3) tick();
        chk("rst_chal_ready", {31'd0, if0.chal_ready}, 0);
        chk("rst_cnt_reset", {31'd0, if0.cnt_reset}, 1);
        chk("rst_cnt_enable", {31'd0, if0.cnt_enable}, 0);
        chk("rst_resp_valid", {31'd0, if0.resp_valid}, 0);
        chk("rst_mux_sel", {24'd0, if0.mux_sel}, 0);
        chk("rst_resp_data", {24'd0, if0.resp_data}, 0);
        chk("rst_flags", {30'd0, if0.tie_seen, if0.timeout_seen}, 0);
        reset = 1'b0;
        #1;
        chk("idle_chal_ready", {31'd0, if0.chal_ready}, 1);

        response(8'h10, 16'h0000);
        held = if0.resp_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_resp_data", {24'd0, if0.resp_data}, {24'd0, held});
            chk("hold_chal_ready", {31'd0, if0.chal_ready}, 0);
            chk("hold_resp_valid", {31'd0, if0.resp_valid}, 1);
        end
        chk("all_a_resp", {24'd0, if0.resp_data}, 32'hFF);
        chk("all_a_flags", {30'd0, if0.tie_seen, if0.timeout_seen}, 0);
        finish_resp();

        response(8'h10, 16'h5555);
        chk("all_b_resp", {24'd0, if0.resp_data}, 32'h00);
        chk("all_b_flags", {30'd0, if0.tie_seen, if0.timeout_seen}, 0);
        finish_resp();

        response(8'hFE, 16'h4444);
        chk("alt_resp", {24'd0, if0.resp_data}, 32'hAA);
        chk("alt_flags", {30'd0, if0.tie_seen, if0.timeout_seen}, 0);
        finish_resp();

        response(8'h40, 16'h0080);
        chk("tie_resp", {24'd0, if0.resp_data}, 32'hEF);
        chk("tie_flags", {30'd0, if0.tie_seen, if0.timeout_seen}, 32'h2);
        finish_resp();

        accept(8'h30);
        race(8'h30, 2'd0);
        race(8'h31, 2'd0);
        n = 0;
        while (!if0.cnt_enable && n < 50) begin tick(); n++; end
        chk("race2_mux_sel", {24'd0, if0.mux_sel}, 32'h32);
        reset = 1'b1;
        tick();
        chk("midrace_cnt_reset", {31'd0, if0.cnt_reset}, 1);
        chk("midrace_cnt_enable", {31'd0, if0.cnt_enable}, 0);
        chk("midrace_chal_ready", {31'd0, if0.chal_ready}, 0);
        chk("midrace_resp_data", {24'd0, if0.resp_data}, 0);
        reset = 1'b0;
        #1;
        chk("post_rst_idle", {31'd0, if0.chal_ready}, 1);
        response(8'h20, 16'h0000);
        chk("post_rst_resp", {24'd0, if0.resp_data}, 32'hFF);
        chk("post_rst_flags", {30'd0, if0.tie_seen, if0.timeout_seen}, 0);
        finish_resp();

        if1.chal_data = 8'h55;
        if1.chal_valid = 1'b1;
        @(posedge clk);
        n = 1;
        #1;
        if1.chal_valid = 1'b0;
        while (!if1.resp_valid && n < 200) begin tick(); n++; end
        chk("timeout_latency", n, 49);
        chk("timeout_resp", {24'd0, if1.resp_data}, 0);
        chk("timeout_flags", {30'd0, if1.tie_seen, if1.timeout_seen}, 32'h1);
        if1.resp_ready = 1'b1;
        tick();
        if1.resp_ready = 1'b0;

        if1.chal_data = 8'h80;
        if1.chal_valid = 1'b1;
        tick();
        if1.chal_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (!if1.cnt_enable && n < 50) begin tick(); n++; end
            chk("edge_mux_sel", {24'd0, if1.mux_sel}, 32'h80 + i);
            repeat (3) tick();
            if1.finished_a = 1'b1;
            tick();
            if1.finished_a = 1'b0;
        end
        n = 0;
        while (!if1.resp_valid && n < 20) begin tick(); n++; end
        chk("edge_resp_valid", {31'd0, if1.resp_valid}, 1);
        chk("edge_resp", {24'd0, if1.resp_data}, 32'hFF);
        chk("edge_flags", {30'd0, if1.tie_seen, if1.timeout_seen}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/puf_race_controller.md
Name: puf_race_controller

Overview:
- Measurement-side controller for the delay-based PUF. Consumes the `finished` pulses from two post-mux counters (path A and path B) and runs one race per response bit.
- Per race: selects a mux challenge, clears both counters, enables them, and records which counter reaches its goal first.
- Packs RESP_BITS race outcomes into a response word, returned over a valid/ready handshake together with tie and timeout flags.

Parameters:
- CHAL_WIDTH, 8, width of challenge / mux_sel.
- RESP_BITS, 8, races per challenge = response width; range 2..32.
- TIMEOUT, 1023, maximum RACE cycles before a race is abandoned; must be >= 2.
- TIMER_W, 10, width of the race timer; must satisfy 2^TIMER_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- chal_valid  in  1  challenge offered.
- chal_ready  out  1  controller can accept a challenge.
- chal_data  in  CHAL_WIDTH  base challenge.
- mux_sel  out  CHAL_WIDTH  select driven to the PUF mux / delay stages.
- cnt_reset  out  1  clear for both post-mux counters.
- cnt_enable  out  1  count enable for both post-mux counters.
- finished_a  in  1  goal-reached pulse, counter A.
- finished_b  in  1  goal-reached pulse, counter B.
- resp_valid  out  1  response available.
- resp_ready  in  1  response consumed.
- resp_data  out  RESP_BITS  packed race results.
- tie_seen  out  1  at least one race of this response tied.
- timeout_seen  out  1  at least one race of this response timed out.

Behaviour:
- Reset:
  - state=IDLE; bit index, timer, challenge, resp_data, mux_sel and both flags = 0.
  - Outputs: resp_valid=0, chal_ready=0 while reset is high, cnt_enable=0, cnt_reset=1.
  - Reset mid-race aborts the response; partial results are discarded.
- State IDLE:
  - chal_ready=1, cnt_reset=1, cnt_enable=0.
  - On chal_valid&&chal_ready: latch chal_data, clear resp_data, flags and index, then go to CLEAR.
- State CLEAR (exactly 1 cycle):
  - cnt_reset=1, cnt_enable=0.
  - mux_sel = latched challenge + index, mod 2^CHAL_WIDTH (wraps: 0xFF+1 -> 0x00).
  - Timer = 0. Next state RACE.
- State RACE:
  - cnt_reset=0, cnt_enable=1, mux_sel held; timer increments each cycle.
  - Winner evaluation, highest priority first:
    - finished_a&&!finished_b -> bit=1.
    - finished_b&&!finished_a -> bit=0.
    - both in the same cycle -> bit=0, set tie_seen.
    - no pulse and timer==TIMEOUT-1 -> bit=0, set timeout_seen.
  - A finished pulse in the timeout cycle wins over the timeout (no timeout flag).
  - On any of the above, go to RECORD.
- State RECORD (1 cycle):
  - cnt_enable=0, cnt_reset=0.
  - resp_data <= {resp_data[RESP_BITS-2:0], bit}, so the first race lands in the MSB.
  - If index==RESP_BITS-1 -> DONE; else index+1 -> CLEAR.
- State DONE:
  - resp_valid=1; resp_data and flags stable until handshake; cnt_reset=1.
  - On resp_ready -> IDLE; chal_ready rises the next cycle (no same-cycle challenge accept).
- Latency:
  - All outputs are decoded from registered state and registers (no input-to-output combinational path).
  - Per race: 1 CLEAR cycle + N RACE cycles + 1 RECORD cycle, where N = cycles to first pulse (N <= TIMEOUT).
  - Challenge accept to resp_valid = sum over races of (N_i + 2) + 1 cycles.
- finished_* outside RACE are ignored. Flags are sticky per response and cleared on the next challenge accept.

Decomposition:
- Package puf_pkg:
  - state encoding IDLE/CLEAR/RACE/RECORD/DONE;
  - default CHAL_WIDTH, RESP_BITS, TIMEOUT;
  - TIMER_W derived by clog2.
- One natural sub-module: puf_race_timer.
  - Cycle counter with synchronous clear, enable and terminal-count output.
  - Shared with future ring-oscillator measurement blocks.

Test Plan:
- Accept 0x10. A pulses 5 cycles into every race, B never pulses -> mux_sel steps 0x10..0x17; resp_data=0xFF; flags 0.
- Accept 0x10. B wins every race -> resp_data=0x00; tie_seen=0; timeout_seen=0.
- Accept 0xFE. A wins races 0,2,4,6 and B wins the others -> resp_data=0xAA; mux_sel wraps 0xFF->0x00->0x01.
- Race 3 has A and B pulsing in the same cycle, A wins the rest -> resp_data=0xEF; tie_seen=1.
- No pulses at all, TIMEOUT=4 -> each race spends 4 RACE cycles; resp_data=0x00; timeout_seen=1; resp_valid 49 cycles after accept.
- reset asserted during race 2, then a new challenge 0x20 where A always wins -> controller returns to IDLE with cnt_reset=1; the next response is 0xFF and flags are clear.
- resp_ready held low 10 cycles -> resp_data stable and chal_ready=0 throughout.
